// File: rtl/serial_operand_serializer.sv
// Parallel-to-serial operand feeder for the bit-serial adder: accepts an A/B pair
// and shifts both out LSB first, driving the adder's carry-clear between words.
module serial_operand_serializer #(
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_a,
    input  logic [W-1:0]         in_b,
    output logic                 a,
    output logic                 b,
    output logic                 bit_valid,
    output logic                 bit_last,
    output logic                 carry_clr,
    output logic [$clog2(W)-1:0] bit_idx
);

    localparam int IW = $clog2(W);
    localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  sh_a, sh_b, sh_a_nxt, sh_b_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic          at_last;
    logic          accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            sh_a  <= sh_a_nxt;
            sh_b  <= sh_b_nxt;
            idx   <= idx_nxt;
        end
    end

    // The last-bit cycle doubles as an accept slot so words can run back to back.
    assign at_last = (state == SHIFT) && (idx == LAST_IDX);
    assign accept  = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        sh_a_nxt  = sh_a;
        sh_b_nxt  = sh_b;
        idx_nxt   = idx;
        in_ready  = (state == IDLE) || at_last;
        carry_clr = (state == IDLE) || at_last;
        bit_valid = (state == SHIFT);
        bit_last  = at_last;
        a         = (state == SHIFT) ? sh_a[0] : 1'b0;
        b         = (state == SHIFT) ? sh_b[0] : 1'b0;
        bit_idx   = idx;

        case (state)
            IDLE: begin
                if (accept) begin
                    sh_a_nxt  = in_a;
                    sh_b_nxt  = in_b;
                    idx_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (at_last && accept) begin
                    sh_a_nxt = in_a;
                    sh_b_nxt = in_b;
                    idx_nxt  = '0;
                end else begin
                    // Zero fill leaves the registers clear once the MSB has gone out.
                    sh_a_nxt = {1'b0, sh_a[W-1:1]};
                    sh_b_nxt = {1'b0, sh_b[W-1:1]};
                    if (at_last) begin
                        idx_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Bench for serial_operand_serializer: vector table, corner sequences, random traffic
// against a word-level model, with a downstream serial adder summing each word.
module tb_serial_operand_serializer;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid = 1'b0, in_ready;
    logic [W-1:0] in_a = '0, in_b = '0;
    logic         a, b, bit_valid, bit_last, carry_clr;
    logic [2:0]   bit_idx;

    logic       v2 = 1'b0, r2;
    logic [1:0] ia2 = '0, ib2 = '0;
    logic       a2, b2, bv2, bl2, cc2;
    logic [0:0] bi2;

    serial_operand_serializer #(.W(W)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .a(a), .b(b), .bit_valid(bit_valid),
        .bit_last(bit_last), .carry_clr(carry_clr), .bit_idx(bit_idx)
    );

    serial_operand_serializer #(.W(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2),
        .in_a(ia2), .in_b(ib2), .a(a2), .b(b2), .bit_valid(bv2),
        .bit_last(bl2), .carry_clr(cc2), .bit_idx(bi2)
    );

    // downstream bit-serial adders
    logic carry = 1'b0, c2 = 1'b0;
    logic sum, sum2;
    assign sum  = a ^ b ^ carry;
    assign sum2 = a2 ^ b2 ^ c2;
    always @(posedge clk) carry <= carry_clr ? 1'b0 : ((a & b) | (a & carry) | (b & carry));
    always @(posedge clk) c2 <= cc2 ? 1'b0 : ((a2 & b2) | (a2 & c2) | (b2 & c2));

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // word-level model: current word, bit position, and expected sums in order
    bit           m_busy = 1'b0;
    int           m_idx = 0;
    logic [W-1:0] m_wa = '0, m_wb = '0;
    logic [W-1:0] q_exp[$];
    logic [W-1:0] sacc = '0;

    function automatic logic [8:0] exp_outs();
        logic lst;
        if (!m_busy) return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0};
        lst = (m_idx == W - 1);
        return {lst, m_wa[m_idx], m_wb[m_idx], 1'b1, lst, lst, 3'(m_idx)};
    endfunction

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_busy = 1'b0;
            m_idx  = 0;
            q_exp.delete();
        end else begin
            bit acc;
            acc = in_valid && (!m_busy || m_idx == W - 1);
            if (m_busy && m_idx < W - 1) m_idx++;
            else if (acc) begin
                m_wa = in_a; m_wb = in_b; m_idx = 0; m_busy = 1'b1;
                q_exp.push_back(in_a + in_b);
            end else begin
                m_busy = 1'b0; m_idx = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("outs", {in_ready, a, b, bit_valid, bit_last, carry_clr, bit_idx}, exp_outs());
            if (m_busy) begin
                sacc[m_idx] = sum;
                if (m_idx == W - 1) begin
                    if (q_exp.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL sum_orphan: got %0h expected none", sacc);
                    end else chk("sum_word", sacc, q_exp.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb);
        int n = 0;
        in_valid = 1'b1; in_a = va; in_b = vb;
        @(negedge clk);
        while (!in_ready) begin
            n++;
            if (n > 50) begin
                checks++; errors++;
                $display("FAIL send_timeout: got in_ready=0 expected 1");
                break;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] a, b;
        int           gap;
        logic [W-1:0] sa, sb, sum;
    } vec_t;
    vec_t tbl[6];

    logic [5:0] w2_exp[5];

    initial begin
        logic [W-1:0] ca, cb, cs;
        int nv;

        tbl[0] = '{8'h5A, 8'h33, 0, 8'h5A, 8'h33, 8'h8D};
        tbl[1] = '{8'hFF, 8'h01, 0, 8'hFF, 8'h01, 8'h00};
        tbl[2] = '{8'h0F, 8'hF0, 0, 8'h0F, 8'hF0, 8'hFF};
        tbl[3] = '{8'hAA, 8'h55, 5, 8'hAA, 8'h55, 8'hFF};
        tbl[4] = '{8'h80, 8'h80, 0, 8'h80, 8'h80, 8'h00};
        tbl[5] = '{8'h01, 8'h01, 0, 8'h01, 8'h01, 8'h02};
        // {bit_valid, bit_last, in_ready, a, b, sum} per cycle for the W=2 pair
        w2_exp[0] = 6'b100_110;
        w2_exp[1] = 6'b111_100;
        w2_exp[2] = 6'b100_000;
        w2_exp[3] = 6'b111_110;
        w2_exp[4] = 6'b001_000;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", {in_ready, a, b, bit_valid, bit_last, carry_clr, bit_idx}, 9'b1_0000_1_000);
        chk("rst_w2", {r2, bv2, bl2, cc2, bi2}, 5'b1_0010);
        chk_en = 1'b1;
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;

        // vector table
        for (int k = 0; k < 6; k++) begin
            send(tbl[k].a, tbl[k].b);
            for (int i = 0; i < W; i++) begin
                @(negedge clk);
                ca[i] = a; cb[i] = b; cs[i] = sum;
            end
            chk("tbl_a", ca, tbl[k].sa);
            chk("tbl_b", cb, tbl[k].sb);
            chk("tbl_sum", cs, tbl[k].sum);
            repeat (tbl[k].gap) begin
                @(negedge clk);
                chk("gap_clr", carry_clr, 1'b1);
            end
        end

        // back-to-back with in_valid held high
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = 8'hFF; in_b = 8'h01;
        @(posedge clk); #1;
        in_a = 8'h01; in_b = 8'h01;
        nv = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bit_valid) nv++;
            if (i == 8) in_valid = 1'b0;
        end
        chk("b2b_valid_cycles", nv, 16);

        // in_valid during a non-last bit is ignored
        @(posedge clk); #1;
        send(8'hC3, 8'h3C);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            ca[i] = a;
            if (i == 3) begin
                chk("busy_ready", in_ready, 1'b0);
                in_valid = 1'b1; in_a = 8'hAA; in_b = 8'h55;
            end
            if (i == 4) in_valid = 1'b0;
        end
        chk("busy_a", ca, 8'hC3);
        @(negedge clk);
        chk("busy_no_word", bit_valid, 1'b0);

        // asynchronous reset mid-word
        @(posedge clk); #1;
        send(8'h0F, 8'hF0);
        repeat (5) @(negedge clk);
        chk("mid_idx", bit_idx, 3'd4);
        #2 rst = 1'b0;
        #1 chk("async_rst", {in_ready, a, b, bit_valid, bit_last, carry_clr, bit_idx}, 9'b1_0000_1_000);
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;
        send(8'h0F, 8'hF0);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            cs[i] = sum;
        end
        chk("post_rst_sum", cs, 8'hFF);

        // random traffic, checked by the model and scoreboard
        @(posedge clk); #1;
        repeat (3000) begin
            in_valid = ($urandom_range(2) != 0);
            in_a = W'($urandom);
            in_b = W'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (W + 2) @(posedge clk);
        #1 chk("sb_drain", q_exp.size(), 0);

        // W=2 back-to-back
        v2 = 1'b1; ia2 = 2'h3; ib2 = 2'h1;
        @(posedge clk); #1;
        ia2 = 2'h2; ib2 = 2'h2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("w2_cycle", {bv2, bl2, r2, a2, b2, sum2}, w2_exp[i]);
            if (i == 2) v2 = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_operand_serializer.md
Name: serial_operand_serializer

Overview:
- Upstream feeder for the bit-serial adder.
- Accepts two W-bit operands through a valid/ready handshake and shifts them out one bit per clock, LSB first, on serial lines `a` and `b`.
- Drives `carry_clr` into the adder's synchronous carry-clear input so every word starts with carry 0.
- Supports back-to-back words with no idle cycle between them.

Parameters:
- W, 8, operand width in bits; legal range W >= 2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair on in_a/in_b is valid.
- in_ready  output  1  block can accept an operand pair this cycle.
- in_a  input  W  operand A, parallel.
- in_b  input  W  operand B, parallel.
- a  output  1  serial bit of A, to adder input a.
- b  output  1  serial bit of B, to adder input b.
- bit_valid  output  1  a/b carry a live operand bit this cycle.
- bit_last  output  1  current bit is the MSB (bit W-1) of the word.
- carry_clr  output  1  to adder carry-clear input; high means the adder carry loads 0 at the next posedge.
- bit_idx  output  $clog2(W)  index of the bit currently on a/b; 0 when idle.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, shift registers = 0, bit_idx = 0.
  - a = b = 0, bit_valid = 0, bit_last = 0, carry_clr = 1, in_ready = 1.
  - Handshakes are ignored while rst is low.
- Accept condition: in_valid && in_ready at a posedge.
- State IDLE:
  - in_ready = 1, carry_clr = 1, bit_valid = 0, a = b = 0.
  - On accept: load shA = in_a, shB = in_b, bit_idx = 0, go to SHIFT.
  - Bit 0 appears on a/b in the first cycle after the accepting edge.
- State SHIFT:
  - a = shA[0], b = shB[0], bit_valid = 1, bit_last = (bit_idx == W-1).
  - Each posedge: shA/shB shift right with zero fill, bit_idx increments.
- Last-bit cycle (bit_idx == W-1):
  - in_ready = 1 and carry_clr = 1.
  - On accept: reload the shift registers, bit_idx = 0, stay in SHIFT. The next word's bit 0 appears the next cycle with no bubble.
  - No accept: go to IDLE.
- Non-last SHIFT cycles: in_ready = 0 and carry_clr = 0.
  - in_valid is ignored; the held in_a/in_b are not sampled.
- Latency and throughput:
  - Accept edge to bit 0 on a/b: 1 cycle.
  - Each word occupies exactly W cycles of bit_valid.
  - Sustained throughput: one word per W cycles.
- carry_clr timing:
  - High in every cycle whose following cycle is not a continuation of the same word (IDLE, and the last bit).
  - Effect: the adder's carry register is 0 whenever bit 0 is presented, and the final carry-out of a word never leaks into the next word.
  - The sum bit in the last-bit cycle is unaffected, because the adder's sum is combinational from the current carry.
- Output timing:
  - a, b, bit_valid, bit_last, bit_idx and carry_clr are functions of registered state only; there is no combinational path from in_valid.
  - in_ready is a function of state and bit_idx only.
- Reset asserted mid-word: the word in flight is abandoned and all outputs take their reset values immediately (asynchronous).

Test Plan:
1. W=8, reset then single word in_a=0x5A, in_b=0x33 -> `a` = 0,1,0,1,1,0,1,0 and `b` = 1,1,0,0,1,1,0,0 over 8 cycles; bit_last only in cycle 8; an adder attached downstream yields sum bits 1,0,1,1,0,0,0,1 (0x8D).
2. Back-to-back 0xFF+0x01 then 0x01+0x01, in_valid held high -> 16 consecutive bit_valid cycles with no gap; in_ready high only in the idle cycle and each last-bit cycle; adder sums 0x00 then 0x02 (carry-out of word 1 cleared by carry_clr).
3. in_valid pulsed with in_a=0xAA, in_b=0x55 during bit_idx=3 of a word in flight -> not accepted; current word's remaining bits unchanged; in_ready=0.
4. rst driven low asynchronously (between edges) at bit_idx=4 of word 0x0F+0xF0 -> a=b=0, bit_valid=0, carry_clr=1, bit_idx=0 immediately; after release, next accepted word starts at bit 0 with correct sum.
5. Idle gap: one word, then in_valid low for 5 cycles, then 0x80+0x80 -> carry_clr=1 throughout the gap; adder sum 0x00, and the carry-out from the MSB does not reach the following word.
6. W=2 instance, words 0x3+0x1 then 0x2+0x2 back-to-back -> bit_last every 2nd cycle, in_ready high each last-bit cycle; sums 0x0 and 0x0.
